// File: rtl/instance_port_arbiter.sv
// instance_port_arbiter: round-robin, packet-atomic arbiter that lets NUM_REQ
// requesters share one downstream valid/ready port. A grant is taken in IDLE
// (one cycle of arbitration latency) and held in BUSY until a last-beat
// transfer. Optional watchdog build macro: INSTANCE_ARB_TIMEOUT_EN.
module instance_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_last,
    input  logic                        out_ready,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy
`ifdef INSTANCE_ARB_TIMEOUT_EN
   ,output logic                        timeout_err
`endif
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]       state;
    logic             armed;     // first edge after reset release only arms
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   pick;
    logic [IDW-1:0]   nxt_ptr;
    logic             xfer;
    logic             wd_fire;
    logic [DATA_W-1:0] data_arr [NUM_REQ];

    // Per-requester payload slicing and ready steering
    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_req
            assign data_arr[g]  = req_data[g*DATA_W +: DATA_W];
            assign req_ready[g] = busy & out_ready & (grant_id == IDW'(g));
        end
    endgenerate

    assign busy     = (state == BUSY);
    assign out_valid = busy & req_valid[grant_id];
    assign out_data = data_arr[grant_id];
    assign out_last = busy & req_last[grant_id];
    assign xfer     = out_valid & out_ready;
    assign nxt_ptr  = (grant_id == IDW'(NUM_REQ-1)) ? '0 : grant_id + IDW'(1);

    // Round-robin search: first valid index at or above ptr, wrapping.
    // Walking k downward lets the smallest offset overwrite last.
    always_comb begin
        logic [IDW:0] idx;
        idx  = '0;
        pick = ptr;
        for (int k = NUM_REQ-1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NUM_REQ)) idx = idx - (IDW+1)'(NUM_REQ);
            if (req_valid[idx[IDW-1:0]]) pick = idx[IDW-1:0];
        end
    end

`ifdef INSTANCE_ARB_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT+1);
    logic [WDW-1:0] wd_cnt;

    // Fires during the TIMEOUT-th consecutive stalled BUSY cycle
    assign wd_fire     = busy & ~xfer & (wd_cnt == WDW'(TIMEOUT-1));
    assign timeout_err = wd_fire;

    // Stall counter: counts BUSY cycles without a transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      wd_cnt <= '0;
        else if (!busy || xfer || wd_fire) wd_cnt <= '0;
        else                             wd_cnt <= wd_cnt + WDW'(1);
    end
`else
    assign wd_fire = 1'b0;
`endif

    // Grant FSM: arbitrate in IDLE, hold the owner until last beat or watchdog
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            armed    <= 1'b0;
            ptr      <= '0;
            grant_id <= '0;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (armed && |req_valid) begin
                        grant_id <= pick;
                        state    <= BUSY;
                    end
                end
                default: begin
                    if ((xfer && req_last[grant_id]) || wd_fire) begin
                        state <= IDLE;
                        ptr   <= nxt_ptr;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instance_port_arbiter.sv
// Bench for instance_port_arbiter: directed scenarios plus random traffic,
// every cycle compared against a packet-level round-robin reference model.
module tb_instance_port_arbiter;
    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int TMO = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_last = '0;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic            out_ready = 1'b0;
    logic [1:0]      grant_id;
    logic            busy;
`ifdef INSTANCE_ARB_TIMEOUT_EN
    logic            timeout_err;
`endif

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: current owner (-1 = none), rotation start, last grant
    int m_owner = -1;
    int m_ptr = 0;
    int m_gid = 0;
    int m_stall = 0;
    bit m_armed = 1'b0;

    int g_log[$];     // grant ids seen on busy rising
    int beat_log[$];  // gid*256 + data of every observed transfer
    int tmo_hits[$];
    bit prev_busy = 1'b0;

    instance_port_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready),
        .grant_id(grant_id), .busy(busy)
`ifdef INSTANCE_ARB_TIMEOUT_EN
       ,.timeout_err(timeout_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_gid = 0; m_stall = 0; m_armed = 1'b0;
    endtask

    task automatic check_outputs();
        bit e_busy, e_ov;
        logic [N-1:0] e_rdy;
        e_busy = (m_owner >= 0);
        e_ov   = 1'b0;
        e_rdy  = '0;
        if (e_busy) begin
            e_ov  = req_valid[m_owner];
            e_rdy = N'(out_ready) << m_owner;
        end
        chk("busy", busy, e_busy);
        chk("grant_id", grant_id, m_gid);
        chk("out_valid", out_valid, e_ov);
        chk("req_ready", req_ready, e_rdy);
        if (e_ov)   chk("out_data", out_data, req_data[m_owner*DW +: DW]);
        if (e_busy) chk("out_last", out_last, req_last[m_owner]);
`ifdef INSTANCE_ARB_TIMEOUT_EN
        chk("timeout_err", timeout_err,
            e_busy && !(e_ov && out_ready) && (m_stall == TMO-1));
`endif
        if (busy && !prev_busy) g_log.push_back(int'(grant_id));
        if (out_valid && out_ready) beat_log.push_back(int'(grant_id)*256 + int'(out_data));
        prev_busy = busy;
    endtask

    // Advance the model across one rising edge using the held inputs
    task automatic model_update();
        bit found;
        int i;
        if (!m_armed) begin
            m_armed = 1'b1;
        end else if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                i = (m_ptr + k) % N;
                if (!found && req_valid[i]) begin
                    found = 1'b1; m_owner = i; m_gid = i;
                end
            end
        end else if (req_valid[m_owner] && out_ready) begin
            m_stall = 0;
            if (req_last[m_owner]) begin
                m_ptr = (m_owner + 1) % N; m_owner = -1;
            end
        end else begin
            m_stall++;
`ifdef INSTANCE_ARB_TIMEOUT_EN
            if (m_stall == TMO) begin
                m_ptr = (m_owner + 1) % N; m_owner = -1; m_stall = 0;
            end
`endif
        end
    endtask

    // Called at posedge+1: drive, check at the falling edge, clock the model
    task automatic step(input logic [N-1:0] v, input logic [N-1:0] l,
                        input logic [N*DW-1:0] d, input logic r);
        req_valid = v; req_last = l; req_data = d; out_ready = r;
        #4;
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Asynchronous reset pulse mid-cycle, released just after an edge
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        prev_busy = 1'b0;
        check_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // Single requester 2: one-cycle latency, one beat, ptr moves to 3
        step(4'b0000, 4'b0000, 32'h0, 1'b1);          // arming edge
        step(4'b0100, 4'b1111, 32'h00C30000, 1'b1);
        chk("r030_gid", grant_id, 2);
        chk("r030_busy", busy, 1);
        step(4'b0100, 4'b1111, 32'h00C30000, 1'b1);
        chk("r030_idle", busy, 0);
        step(4'b1111, 4'b1111, 32'h44332211, 1'b1);
        chk("r030_next", grant_id, 3);
        step(4'b1111, 4'b1111, 32'h44332211, 1'b1);

        // All valid, single-beat: 0,1,2,3,0 with a bubble between grants
        do_reset();
        step(4'b1111, 4'b1111, 32'h44332211, 1'b1);   // arming: no grant
        g_log.delete();
        for (int s = 0; s < 10; s++) step(4'b1111, 4'b1111, 32'h44332211, 1'b1);
        chk("r031_cnt", g_log.size(), 5);
        if (g_log.size() == 5) begin
            chk("r031_g0", g_log[0], 0); chk("r031_g1", g_log[1], 1);
            chk("r031_g2", g_log[2], 2); chk("r031_g3", g_log[3], 3);
            chk("r031_g4", g_log[4], 0);
        end

        // Requester 1 three-beat packet with requester 0 waiting
        do_reset();
        step(4'b0000, 4'b0000, 32'h0, 1'b1);
        step(4'b0001, 4'b0001, 32'h000000A0, 1'b1);
        step(4'b0001, 4'b0001, 32'h000000A0, 1'b1);   // ptr -> 1
        beat_log.delete();
        step(4'b0011, 4'b0001, 32'h000011A0, 1'b1);
        step(4'b0011, 4'b0001, 32'h000011A0, 1'b1);
        step(4'b0011, 4'b0001, 32'h000022A0, 1'b0);
        step(4'b0011, 4'b0001, 32'h000022A0, 1'b1);
        step(4'b0011, 4'b0011, 32'h000033A0, 1'b1);
        step(4'b0011, 4'b0011, 32'h000033A0, 1'b1);
        step(4'b0011, 4'b0011, 32'h000033A0, 1'b1);
        chk("r032_cnt", beat_log.size(), 4);
        if (beat_log.size() == 4) begin
            chk("r032_b0", beat_log[0], 32'h111); chk("r032_b1", beat_log[1], 32'h122);
            chk("r032_b2", beat_log[2], 32'h133); chk("r032_b3", beat_log[3], 32'h0A0);
        end

        // Watchdog on a stalled grant to requester 3
        do_reset();
        step(4'b0000, 4'b0000, 32'h0, 1'b0);
        step(4'b1000, 4'b1000, 32'h5A000000, 1'b0);
        chk("r033_gid", grant_id, 3);
        tmo_hits.delete();
`ifdef INSTANCE_ARB_TIMEOUT_EN
        for (int s = 1; s <= TMO; s++) begin
            req_valid = 4'b1001; req_last = 4'b1001; req_data = 32'h5A0000B1; out_ready = 1'b0;
            #4;
            if (timeout_err) tmo_hits.push_back(s);
            check_outputs();
            @(posedge clk); model_update(); #1;
        end
        chk("r033_hits", tmo_hits.size(), 1);
        if (tmo_hits.size() == 1) chk("r033_when", tmo_hits[0], TMO);
        step(4'b1001, 4'b1001, 32'h5A0000B1, 1'b0);
        chk("r033_next", grant_id, 0);
`else
        for (int s = 0; s < TMO + 4; s++) step(4'b1001, 4'b1001, 32'h5A0000B1, 1'b0);
        chk("r033_hold", busy, 1);
        chk("r033_hold_gid", grant_id, 3);
`endif

        // Reset during beat 2 of a packet from requester 2
        do_reset();
        step(4'b0000, 4'b0000, 32'h0, 1'b1);
        step(4'b0100, 4'b0000, 32'h00E10000, 1'b1);
        step(4'b0100, 4'b0000, 32'h00E10000, 1'b1);   // beat 1 transfers
        req_valid = 4'b0101; req_data = 32'h00E200F0;
        do_reset();
        chk("r034_ov", out_valid, 0);
        chk("r034_rdy", req_ready, 0);
        step(4'b0101, 4'b0101, 32'h00E200F0, 1'b1);   // arming edge
        step(4'b0101, 4'b0101, 32'h00E200F0, 1'b1);
        chk("r034_gid", grant_id, 0);
        step(4'b0101, 4'b0101, 32'h00E200F0, 1'b1);

        // Random traffic with occasional resets
        for (int s = 0; s < 400; s++) begin
            if ($urandom_range(0, 79) == 0) do_reset();
            step(N'($urandom), N'($urandom) & N'($urandom), $urandom,
                 ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/instance_port_arbiter.md
INSTANCE_PORT_ARBITER -- requirements
Module: instance_port_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesting instances sharing one downstream port (2..8).
REQ-002 Parameter DATA_W, default 8, payload width per beat.
REQ-003 Parameter TIMEOUT, default 16, stall-cycle limit for the watchdog (REQ-024).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-006 req_valid  input  NUM_REQ  per-requester beat valid.
REQ-007 req_data  input  NUM_REQ*DATA_W  per-requester payload; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-008 req_last  input  NUM_REQ  per-requester last-beat-of-packet flag.
REQ-009 req_ready  output  NUM_REQ  per-requester accept.
REQ-010 out_valid  output  1  downstream beat valid.
REQ-011 out_data  output  DATA_W  downstream payload.
REQ-012 out_last  output  1  downstream last-beat flag.
REQ-013 out_ready  input  1  downstream accept.
REQ-014 grant_id  output  $clog2(NUM_REQ)  index of the current owner.
REQ-015 busy  output  1  high while a grant is held.
REQ-016 timeout_err  output  1  one-cycle pulse on watchdog expiry; present only with the macro in REQ-029.

Function
REQ-017 Two states: IDLE and BUSY.
REQ-018 IDLE: out_valid=0 and req_ready=0; when any req_valid is high, select the first asserted index searching upward from ptr with wrap-around, register it into grant_id, and enter BUSY on the next edge (one cycle arbitration latency).
REQ-019 BUSY: out_valid=req_valid[grant_id], out_data=req_data[grant_id], out_last=req_last[grant_id], and req_ready[grant_id]=out_ready, all combinational; every other req_ready bit is 0.
REQ-020 Transfer occurs when out_valid and out_ready are both high; a transfer with out_last=1 returns to IDLE and sets ptr=(grant_id+1) mod NUM_REQ.
REQ-021 Grant is never preempted mid-packet by any other requester's req_valid.
REQ-022 Dropping req_valid[grant_id] mid-packet keeps the grant; out_valid follows it low.
REQ-023 The IDLE cycle after a packet is mandatory: back-to-back packets from different requesters have a one-cycle bubble.
REQ-024 Watchdog (macro only): a counter increments each BUSY cycle without a transfer and clears on every transfer; when it reaches TIMEOUT, return to IDLE, advance ptr as in REQ-020, and pulse timeout_err for one cycle.
REQ-025 busy=1 exactly in BUSY; grant_id holds its last value while IDLE.

Reset
REQ-026 rst_n low asynchronously forces IDLE, ptr=0, grant_id=0, busy=0, watchdog counter=0, and timeout_err=0; out_valid and req_ready are therefore 0.
REQ-027 Reset mid-packet abandons the packet with no completion signalling; the first grant after release goes to the lowest valid index starting at 0.
REQ-028 Deassertion is sampled on clk; the earliest grant is two edges after rst_n rises.

Configuration
REQ-029 Macro INSTANCE_ARB_TIMEOUT_EN: when defined, the watchdog, its counter, and the timeout_err port are compiled in; when undefined, the counter and port are absent, and BUSY exits only on a last-beat transfer.

Verification
REQ-030 Reset, then req_valid=4'b0100 with req_last=1 and out_ready=1 -> grant_id=2 one cycle later, one beat forwarded, busy pulses for 1 cycle, ptr=3.
REQ-031 All four requesters continuously valid, single-beat packets -> grant order 0,1,2,3,0, with exactly one idle bubble between each grant.
REQ-032 Requester 1 sends a 3-beat packet (data 0x11,0x22,0x33) while requester 0 stays valid and out_ready toggles 1,0,1,1 -> all three beats are forwarded in order with no switch to requester 0 until after 0x33.
REQ-033 With the macro defined and TIMEOUT=16: requester 3 granted, out_ready held 0 -> timeout_err is high exactly at the 16th stall cycle, the next grant goes to index 0 if valid, and no error is raised without the macro.
REQ-034 rst_n pulsed low during beat 2 of a packet from requester 2 -> outputs immediately take their REQ-026 values, and after release requester 0 is granted ahead of requester 2.
